// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_pkg
// Brief  : Shared unit codes and writeback entry layout for the writeback stage
// Rev    : 1.0  initial release
// ============================================================================
package wb_pkg;

    typedef enum logic [2:0] {
        FXUnitCode     = 3'd0,
        FPUnitCode     = 3'd1,
        LdStUnitCode   = 3'd2,
        BranchUnitCode = 3'd3,
        TrapUnitCode   = 3'd4
    } wb_unit_code_e;

    localparam int C_DEF_UNIT_CODE_W = 3;
    localparam int C_DEF_REG_W       = 5;
    localparam int C_DEF_DATA_W      = 64;

    // Entry packing, MSB first: {unit, en1, en2, addr1, addr2, val1, val2}
    function automatic int wb_entry_width(input int unit_w, input int reg_w, input int data_w);
        return unit_w + 2 + 2 * reg_w + 2 * data_w;
    endfunction

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_source_fifo.sv
`default_nettype none
// ============================================================================
// Module : wb_source_fifo
// Brief  : Synchronous single-clock FIFO holding one source's pending results
// Rev    : 1.0  initial release
// ============================================================================
module wb_source_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == C_CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule : wb_source_fifo
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module : writeback_arbiter
// Brief  : Per-source result FIFOs drained one per cycle by round-robin grant
// Rev    : 1.0  initial release
// ============================================================================
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int numSources    = 3,
    parameter int fifoDepth     = 4,
    parameter int regWidth      = 5,
    parameter int dataWidth     = 64,
    parameter int unitCodeWidth = 3
) (
    input  logic                                clock_i,
    input  logic                                reset_i,
    input  logic [numSources-1:0]               srcValid_i,
    output logic [numSources-1:0]               srcReady_o,
    input  logic [numSources*unitCodeWidth-1:0] srcUnitCode_i,
    input  logic [numSources-1:0]               srcReg1Enable_i,
    input  logic [numSources-1:0]               srcReg2Enable_i,
    input  logic [numSources*regWidth-1:0]      srcReg1Address_i,
    input  logic [numSources*regWidth-1:0]      srcReg2Address_i,
    input  logic [numSources*dataWidth-1:0]     srcReg1Value_i,
    input  logic [numSources*dataWidth-1:0]     srcReg2Value_i,
    output logic                                wbValid_o,
    output logic [unitCodeWidth-1:0]            functionalUnitCode_o,
    output logic                                reg1WritebackEnable_o,
    output logic                                reg2WritebackEnable_o,
    output logic [regWidth-1:0]                 reg1WritebackAddress_o,
    output logic [regWidth-1:0]                 reg2WritebackAddress_o,
    output logic [dataWidth-1:0]                reg1WritebackVal_o,
    output logic [dataWidth-1:0]                reg2WritebackVal_o,
    output logic [$clog2(numSources)-1:0]       grantSource_o
);

    localparam int C_SRC_W   = $clog2(numSources);
    localparam int C_ENTRY_W = wb_entry_width(unitCodeWidth, regWidth, dataWidth);
    localparam int C_V2_LO   = 0;
    localparam int C_V1_LO   = C_V2_LO + dataWidth;
    localparam int C_A2_LO   = C_V1_LO + dataWidth;
    localparam int C_A1_LO   = C_A2_LO + regWidth;
    localparam int C_EN2_BIT = C_A1_LO + regWidth;
    localparam int C_EN1_BIT = C_EN2_BIT + 1;
    localparam int C_UC_LO   = C_EN1_BIT + 1;

    logic [C_ENTRY_W-1:0] w_in_entry [numSources];
    logic [C_ENTRY_W-1:0] w_head     [numSources];
    logic [numSources-1:0] w_push;
    logic [numSources-1:0] w_full;
    logic [numSources-1:0] w_empty;
    logic [numSources-1:0] w_grant_oh;
    logic                  w_grant_valid;
    logic [C_SRC_W-1:0]    w_grant_idx;
    logic [C_ENTRY_W-1:0]  w_sel;
    int                    w_cand;

    logic [C_SRC_W-1:0]       r_last_grant;
    logic                     r_wb_valid;
    logic [unitCodeWidth-1:0] r_unit_code;
    logic                     r_en1;
    logic                     r_en2;
    logic [regWidth-1:0]      r_addr1;
    logic [regWidth-1:0]      r_addr2;
    logic [dataWidth-1:0]     r_val1;
    logic [dataWidth-1:0]     r_val2;
    logic [C_SRC_W-1:0]       r_grant;

    // Ready depends on registered occupancy only; a pop in the same cycle does not free a slot
    assign srcReady_o = reset_i ? '0 : ~w_full;

    generate
        for (genvar s = 0; s < numSources; s++) begin : g_src
            assign w_in_entry[s] = {srcUnitCode_i[s*unitCodeWidth +: unitCodeWidth],
                                    srcReg1Enable_i[s], srcReg2Enable_i[s],
                                    srcReg1Address_i[s*regWidth +: regWidth],
                                    srcReg2Address_i[s*regWidth +: regWidth],
                                    srcReg1Value_i[s*dataWidth +: dataWidth],
                                    srcReg2Value_i[s*dataWidth +: dataWidth]};
            // Results that write nothing complete the handshake but never reach the FIFO
            assign w_push[s] = srcValid_i[s] && srcReady_o[s]
                             && (srcReg1Enable_i[s] || srcReg2Enable_i[s]);

            wb_source_fifo #(
                .DEPTH (fifoDepth),
                .WIDTH (C_ENTRY_W)
            ) u_fifo (
                .clk     (clock_i),
                .rst     (reset_i),
                .i_push  (w_push[s]),
                .i_data  (w_in_entry[s]),
                .i_pop   (w_grant_oh[s]),
                .o_data  (w_head[s]),
                .o_full  (w_full[s]),
                .o_empty (w_empty[s])
            );
        end
    endgenerate

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_cand        = 0;
        for (int i = 1; i <= numSources; i++) begin
            w_cand = int'(r_last_grant) + i;
            if (w_cand >= numSources) begin
                w_cand = w_cand - numSources;
            end
            if (!w_grant_valid && !w_empty[w_cand]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_cand[C_SRC_W-1:0];
            end
        end
    end

    always_comb begin
        w_grant_oh = '0;
        w_sel      = '0;
        for (int s = 0; s < numSources; s++) begin
            if (w_grant_valid && (w_grant_idx == C_SRC_W'(s))) begin
                w_grant_oh[s] = 1'b1;
                w_sel         = w_head[s];
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_last_grant <= C_SRC_W'(numSources - 1);
            r_wb_valid   <= 1'b0;
            r_unit_code  <= '0;
            r_en1        <= 1'b0;
            r_en2        <= 1'b0;
            r_addr1      <= '0;
            r_addr2      <= '0;
            r_val1       <= '0;
            r_val2       <= '0;
            r_grant      <= '0;
        end else if (w_grant_valid) begin
            r_last_grant <= w_grant_idx;
            r_wb_valid   <= 1'b1;
            r_unit_code  <= w_sel[C_UC_LO +: unitCodeWidth];
            r_en1        <= w_sel[C_EN1_BIT];
            r_en2        <= w_sel[C_EN2_BIT];
            r_addr1      <= w_sel[C_A1_LO +: regWidth];
            r_addr2      <= w_sel[C_A2_LO +: regWidth];
            r_val1       <= w_sel[C_V1_LO +: dataWidth];
            r_val2       <= w_sel[C_V2_LO +: dataWidth];
            r_grant      <= w_grant_idx;
        end else begin
            r_wb_valid   <= 1'b0;
            r_en1        <= 1'b0;
            r_en2        <= 1'b0;
        end
    end

    assign wbValid_o              = r_wb_valid;
    assign functionalUnitCode_o   = r_unit_code;
    assign reg1WritebackEnable_o  = r_en1;
    assign reg2WritebackEnable_o  = r_en2;
    assign reg1WritebackAddress_o = r_addr1;
    assign reg2WritebackAddress_o = r_addr2;
    assign reg1WritebackVal_o     = r_val1;
    assign reg2WritebackVal_o     = r_val2;
    assign grantSource_o          = r_grant;

endmodule : writeback_arbiter
`default_nettype wire
